// File: rtl/display_scan.sv
// display_scan: time-multiplexed seven-segment driver for a signed BCD result.
// Latches q/neg/err on load. Formats the value with leading-zero blanking,
// a minus sign and an "Err" indication. Scans one digit per SCAN_DIV cycles
// and can optionally blink the whole display.
// Ports:
//   clk, rst       - system clock, asynchronous active-high reset
//   load           - capture q/neg/err on this edge
//   q              - NUM BCD nibbles, nibble 0 least significant
//   neg, err       - sign and error flags of the result
//   blink_en       - enable whole-display blinking
//   seg            - active-low segments {g,f,e,d,c,b,a}
//   an             - active-low one-hot digit enable, an[0] rightmost
//   frame          - one-cycle pulse when the scan wraps to digit 0
module display_scan #(
  parameter int DIGITS    = 8,
  parameter int NUM       = 5,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [4*NUM-1:0]  q,
  input  logic              neg,
  input  logic              err,
  input  logic              blink_en,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              frame
);
  localparam int IW = $clog2(DIGITS);
  localparam int HW = IW + 1;
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV + 1);

  localparam logic [6:0] BLANK   = 7'b1111111;
  localparam logic [6:0] MINUS   = 7'b0111111;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_R = 7'b0101111;

  function automatic logic [6:0] bcd7(input logic [3:0] d);
    case (d)
      4'd0:    bcd7 = 7'b1000000;
      4'd1:    bcd7 = 7'b1111001;
      4'd2:    bcd7 = 7'b0100100;
      4'd3:    bcd7 = 7'b0110000;
      4'd4:    bcd7 = 7'b0011001;
      4'd5:    bcd7 = 7'b0010010;
      4'd6:    bcd7 = 7'b0000010;
      4'd7:    bcd7 = 7'b1111000;
      4'd8:    bcd7 = 7'b0000000;
      4'd9:    bcd7 = 7'b0010000;
      default: bcd7 = BLANK;
    endcase
  endfunction

  logic [4*NUM-1:0] val;
  logic             neg_r, err_r;
  logic [DW-1:0]    div;
  logic [IW-1:0]    idx;
  logic [BW-1:0]    bcnt;
  logic             vis;

  logic div_tc, wrap;
  assign div_tc = (div == DW'(SCAN_DIV - 1));
  assign wrap   = div_tc && (idx == IW'(DIGITS - 1));

  // Glyph for the digit currently selected by idx, from the latched result.
  logic            bad, nz;
  logic [HW-1:0]   h;
  logic [3:0]      nib;
  logic [6:0]      glyph;

  always_comb begin
    bad = err_r;
    h   = '0;
    nib = '0;
    for (int i = 0; i < NUM; i++) begin
      if (val[4*i +: 4] > 4'd9)  bad = 1'b1;
      if (val[4*i +: 4] != 4'd0) h   = HW'(i);
      if (idx == IW'(i))         nib = val[4*i +: 4];
    end
    nz    = |val;
    glyph = BLANK;
    if (bad) begin
      if (idx == IW'(2))     glyph = GLYPH_E;
      else if (idx < IW'(2)) glyph = GLYPH_R;
    end else if ({1'b0, idx} <= h) begin
      glyph = bcd7(nib);
    end else if (neg_r && nz && ({1'b0, idx} == h + HW'(1))) begin
      // negative zero never gets a sign
      glyph = MINUS;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val   <= '0;
      neg_r <= 1'b0;
      err_r <= 1'b0;
      div   <= '0;
      idx   <= '0;
      bcnt  <= '0;
      vis   <= 1'b1;
      seg   <= BLANK;
      an    <= '1;
      frame <= 1'b0;
    end else begin
      if (load) begin
        val   <= q;
        neg_r <= neg;
        err_r <= err;
      end
      div <= div_tc ? '0 : div + 1'b1;
      if (div_tc) idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      frame <= wrap;
      // load restarts the blink phase so a fresh result shows at once
      if (load) begin
        bcnt <= '0;
        vis  <= 1'b1;
      end else if (wrap) begin
        if (bcnt == BW'(BLINK_DIV - 1)) begin
          bcnt <= '0;
          vis  <= ~vis;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
      // seg and an share one edge so digits never ghost
      seg <= glyph;
      an  <= (blink_en && !vis) ? '1 : ~(DIGITS'(1) << idx);
    end
  end
endmodule

// File: tb/tb_display_scan.sv
module tb_display_scan;
  localparam int DIGITS = 8, NUM = 5, SCAN_DIV = 4, BLINK_DIV = 2;
  localparam int FRAME = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst, load, neg, err, blink_en;
  logic [19:0] q;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic        frame;

  display_scan #(.DIGITS(DIGITS), .NUM(NUM), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst(rst), .load(load), .q(q), .neg(neg), .err(err),
    .blink_en(blink_en), .seg(seg), .an(an), .frame(frame)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;

  // Reference model: edges since reset, frame wraps since last load, latched result.
  int          e, wraps;
  logic [19:0] lq;
  bit          lneg, lerr;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_frame;

  // Text shown on the display, rightmost character first, then mapped to segments.
  function automatic logic [6:0] ref_glyph(int pos, logic [19:0] v, bit n, bit er);
    byte txt[$];
    int  top;
    bit  bad;
    byte c;
    bad = er;
    for (int i = 0; i < NUM; i++) if (v[4*i +: 4] > 4'd9) bad = 1;
    if (bad) begin
      txt.push_back("r"); txt.push_back("r"); txt.push_back("E");
    end else begin
      top = 0;
      for (int i = 0; i < NUM; i++) if (v[4*i +: 4] != 4'd0) top = i;
      for (int i = 0; i <= top; i++) txt.push_back(byte'(8'd48 + {4'd0, v[4*i +: 4]}));
      if (n && v != 20'd0) txt.push_back("-");
    end
    if (pos >= txt.size()) return 7'b1111111;
    c = txt[pos];
    case (c)
      "0": return 7'b1000000;
      "1": return 7'b1111001;
      "2": return 7'b0100100;
      "3": return 7'b0110000;
      "4": return 7'b0011001;
      "5": return 7'b0010010;
      "6": return 7'b0000010;
      "7": return 7'b1111000;
      "8": return 7'b0000000;
      "9": return 7'b0010000;
      "-": return 7'b0111111;
      "E": return 7'b0000110;
      "r": return 7'b0101111;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic reset_model();
    e = 0; wraps = 0; lq = '0; lneg = 0; lerr = 0;
  endtask

  // Advance one clock edge; expected outputs after the edge come from the model state before it.
  task automatic step();
    int cur;
    bit vis;
    cur     = (e / SCAN_DIV) % DIGITS;
    vis     = ((wraps / BLINK_DIV) % 2) == 0;
    exp_seg = ref_glyph(cur, lq, lneg, lerr);
    exp_an  = (blink_en && !vis) ? 8'hFF : ~(8'h01 << cur);
    e++;
    if (load) begin
      lq = q; lneg = neg; lerr = err; wraps = 0;
    end else if (e % FRAME == 0) begin
      wraps++;
    end
    exp_frame = (e % FRAME == 0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int pulses;
    rst = 1; load = 0; q = '0; neg = 0; err = 0; blink_en = 0;
    #2;
    total++;
    if (an !== 8'hFF) $display("FAIL reset_an got %b want 11111111", an); else passed++;
    total++;
    if (seg !== 7'h7F) $display("FAIL reset_seg got %b want 1111111", seg); else passed++;
    total++;
    if (frame !== 1'b0) $display("FAIL reset_frame got %b want 0", frame); else passed++;
    @(posedge clk); #3;
    rst = 0;
    reset_model();
    pulses = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (frame === 1'b1) pulses++;
      total++;
      if (an !== exp_an || seg !== exp_seg || frame !== exp_frame)
        $display("FAIL reset_scan[%0d] an=%b want %b seg=%b want %b frame=%b want %b",
                 i, an, exp_an, seg, exp_seg, frame, exp_frame);
      else passed++;
    end
    total++;
    if (pulses != 2) $display("FAIL frame_count got %0d want 2", pulses); else passed++;
  endtask

  task automatic test_values();
    logic [19:0] tq[6]  = '{20'h00123, 20'h0A012, 20'h00005, 20'h00000, 20'h99999, 20'h10000};
    bit          tn[6]  = '{1, 0, 0, 1, 1, 0};
    bit          te[6]  = '{0, 0, 1, 0, 0, 0};
    blink_en = 0;
    for (int k = 0; k < 6; k++) begin
      q = tq[k]; neg = tn[k]; err = te[k]; load = 1;
      step();
      load = 0;
      for (int i = 0; i <= FRAME; i++) begin
        step();
        total++;
        if (an !== exp_an || seg !== exp_seg || frame !== exp_frame)
          $display("FAIL value_%05h[%0d] an=%b want %b seg=%b want %b frame=%b want %b",
                   tq[k], i, an, exp_an, seg, exp_seg, frame, exp_frame);
        else passed++;
      end
    end
  endtask

  task automatic test_blink();
    int guard;
    blink_en = 1; q = 20'h00042; neg = 0; err = 0; load = 1;
    step();
    load = 0;
    for (int i = 0; i < 4 * FRAME + 8; i++) begin
      step();
      total++;
      if (an !== exp_an || seg !== exp_seg || frame !== exp_frame)
        $display("FAIL blink[%0d] an=%b want %b seg=%b want %b", i, an, exp_an, seg, exp_seg);
      else passed++;
    end
    guard = 0;
    while (exp_an !== 8'hFF && guard < 4 * FRAME) begin
      step();
      guard++;
    end
    total++;
    if (an !== 8'hFF) $display("FAIL blink_off got %b want 11111111", an); else passed++;
    load = 1;
    step();
    load = 0;
    step();
    total++;
    if (an === 8'hFF || an !== exp_an)
      $display("FAIL blink_reload an=%b want %b", an, exp_an);
    else passed++;
    blink_en = 0;
  endtask

  task automatic test_random();
    logic [19:0] v;
    int          len, hold, run;
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        len = $urandom_range(0, 5);
        v = '0;
        for (int d = 0; d < len; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
      end else begin
        v = 20'($urandom);
      end
      q = v; neg = 1'($urandom_range(0, 1)); err = ($urandom_range(0, 7) == 0);
      blink_en = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 3);
      load = 1;
      for (int i = 0; i < hold; i++) step();
      load = 0;
      run = $urandom_range(20, 45);
      for (int i = 0; i < run; i++) begin
        step();
        total++;
        if (an !== exp_an || seg !== exp_seg || frame !== exp_frame)
          $display("FAIL random_%05h[%0d] an=%b want %b seg=%b want %b frame=%b want %b",
                   v, i, an, exp_an, seg, exp_seg, frame, exp_frame);
        else passed++;
      end
    end
    blink_en = 0;
  endtask

  task automatic test_async_reset();
    blink_en = 0; q = 20'h00007; neg = 0; err = 0; load = 1;
    step();
    load = 0;
    for (int i = 0; i < 13; i++) step();
    #3;
    rst = 1;
    #1;
    total++;
    if (an !== 8'hFF) $display("FAIL async_an got %b want 11111111", an); else passed++;
    total++;
    if (seg !== 7'h7F) $display("FAIL async_seg got %b want 1111111", seg); else passed++;
    #1;
    rst = 0;
    reset_model();
    for (int i = 0; i < FRAME; i++) begin
      step();
      total++;
      if (an !== exp_an || seg !== exp_seg || frame !== exp_frame)
        $display("FAIL async_restart[%0d] an=%b want %b seg=%b want %b", i, an, exp_an, seg, exp_seg);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_values();
    test_blink();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/display_scan.md
# display_scan

Parametrised, time-multiplexed seven-segment driver for calculator results. It latches a signed BCD result with a load strobe, formats it for display, and scans it onto a shared active-low segment bus with one-hot active-low digit enables. Formatting covers leading-zero blanking, a minus sign, an "Err" indication and optional blinking. It sits between the arithmetic result registers and the board's multiplexed display pins.

## Interface
- DIGITS, 8, physical digit positions; 3..8
- NUM, 5, BCD digits in `q`; 1..DIGITS-1
- SCAN_DIV, 50000, clock cycles each digit stays enabled; >=2
- BLINK_DIV, 16, full scan frames per blink half-period; >=1

Ports:
- clk  in  1  system clock; all state on the rising edge
- rst  in  1  asynchronous, active-high reset
- load  in  1  on a clk edge where high, capture `q`, `neg`, `err`
- q  in  4*NUM  BCD value; nibble 0 = least significant digit
- neg  in  1  result is negative
- err  in  1  overflow or invalid result
- blink_en  in  1  enables blinking of the whole display
- seg  out  7  active-low segments, order {g,f,e,d,c,b,a}
- an  out  DIGITS  active-low one-hot digit enable; an[0] = rightmost digit
- frame  out  1  one-cycle pulse when the scan wraps

## Operation
- Latch: holds `val`, `neg_r`, `err_r`. Reset clears all three, so the display shows "0".
- Error mode: active when `err_r` is set or any `val` nibble is greater than 9.
  - Shows "Err" right-aligned: d2=E (0000110), d1=r (0101111), d0=r (0101111).
  - All other digits are blank (1111111).
- Normal mode:
  - Let h = index of the highest nonzero nibble; h = 0 if the value is zero.
  - Digits 0..h show the decoded value: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - If `neg_r` is set and the value is nonzero, digit h+1 shows minus (0111111). A negative zero shows "0" with no sign.
  - All remaining digits, including every position at or above NUM, are blank.
- Scan:
  - `div` counts 0..SCAN_DIV-1.
  - On the terminal count, `idx` advances 0..DIGITS-1 and wraps to 0.
  - `frame` pulses for one cycle on the wrap from DIGITS-1 to 0.
- Blink:
  - `bcnt` counts frames 0..BLINK_DIV-1. At its terminal count the `vis` phase toggles.
  - While `blink_en` is high and `vis` is 0, `an` is forced to all ones. `seg` still updates.
  - While `blink_en` is low, `vis` is ignored for output.
  - `load` clears `bcnt` and sets `vis` to 1, so a new result appears immediately.
  - `load` does not disturb `div` or `idx`.
- Outputs: `seg` and `an` are registered together on the same edge, so no ghosting occurs between digits.

## Timing
- Reset values, applied asynchronously while `rst` is high:
  - `an` = all ones, `seg` = 1111111, `frame` = 0
  - `div` = 0, `idx` = 0, `bcnt` = 0, `vis` = 1
  - `val` = 0, `neg_r` = 0, `err_r` = 0
- First edge after reset release: `an` = ~1 (digit 0 enabled) and `seg` = "0".
- Output timing:
  - `seg` and `an` at edge k reflect `idx` and latch contents as they were after edge k-1.
  - `load` sampled at edge N is therefore visible on `seg` from edge N+1 for the currently enabled digit.
- Digit dwell: exactly SCAN_DIV cycles. Frame: DIGITS*SCAN_DIV cycles.
- Blink half-period: BLINK_DIV frames.
- Simultaneous events:
  - `load` at the same edge as a blink terminal count: `load` wins, giving `bcnt` = 0 and `vis` = 1.
  - `load` held high: the latch recaptures every edge.
- Reset mid-scan or mid-blink: all state returns to reset values immediately, without waiting for a clock edge.

## Test plan
All scenarios use DIGITS=8, NUM=5, SCAN_DIV=4, BLINK_DIV=2.
- Reset and release: during reset, `an`=11111111 and `seg`=1111111. After release, over one 32-cycle frame, d0=1000000 and d1..d7 are blank. `frame` pulses once every 32 cycles.
- Negative value: load q=20'h00123, neg=1 → d0=0110000, d1=0100100, d2=1111001, d3=0111111, d4..d7 blank.
- Error display: load q=20'h0A012 → d2=0000110, d1=0101111, d0=0101111, rest blank. Loading q=20'h00005 with err=1 gives the same pattern.
- Edge values:
  - q=0, neg=1 → "0" only, no minus.
  - q=20'h99999, neg=1 → 0010000 on d0..d4 and minus on d5.
  - q=20'h10000, neg=0 → d4=1111001 and d0..d3=1000000.
- Blink: with blink_en=1, `an` is active for 2 frames, then all ones for 2 frames, repeating. Pulsing `load` during the off phase re-enables `an` on the next edge.
- Asynchronous reset: assert `rst` mid-dwell between clock edges → `an` and `seg` go to all ones before the next clk edge. Scan restarts at d0 after release.
